// File: rtl/flexi_packet_parser_if.sv
// Stream bus for flexi_packet_parser: framed words in,
// extracted payload words plus frame status out.
interface flexi_packet_parser_if;
  logic        validIn;
  logic [31:0] dataIn;
  logic        lastIn;
  logic        validOut;
  logic [31:0] dataOut;
  logic        lastOut;
  logic [15:0] seqOut;
  logic        pktDone;
  logic [3:0]  errCode;
  logic [15:0] goodCount;
  logic [15:0] errCount;

  modport master (
    output validIn, dataIn, lastIn,
    input  validOut, dataOut, lastOut, seqOut,
    input  pktDone, errCode, goodCount, errCount
  );

  modport slave (
    input  validIn, dataIn, lastIn,
    output validOut, dataOut, lastOut, seqOut,
    output pktDone, errCode, goodCount, errCount
  );
endinterface

// File: rtl/flexi_packet_parser.sv
// Header/payload/footer frame parser with per-frame
// error flags, sequence tracking and frame counters.
module flexi_packet_parser #(
  parameter int          MAX_PAYLOAD = 100,
  parameter logic [31:0] FOOTER_WORD = 32'hFFFFFFFF
) (
  input logic              clk,
  input logic              resetn,
  flexi_packet_parser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    FOOTER,
    DROP
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [3:0]  err_q, err_d;
  logic        vout_q, vout_d;
  logic [31:0] dout_q, dout_d;
  logic        lout_q, lout_d;
  logic [15:0] seq_q, seq_d;
  logic        done_q, done_d;
  logic [3:0]  ecode_q, ecode_d;
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;

  logic [15:0] hdr_seq;
  logic [8:0]  hdr_rsv;
  logic [6:0]  hdr_len;
  logic        hdr_bad;
  logic [6:0]  cnt_inc;

  assign hdr_seq = bus.dataIn[31:16];
  assign hdr_rsv = bus.dataIn[15:7];
  assign hdr_len = bus.dataIn[6:0];
  assign hdr_bad = (hdr_rsv != 9'd0) || (hdr_len == 7'd0)
                || ({25'd0, hdr_len} > 32'(MAX_PAYLOAD));
  assign cnt_inc = cnt_q + 7'd1;

  // Next-state, output and counter logic for each valid beat
  always_comb begin
    logic       term;
    logic [3:0] e;
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;
    vout_d  = 1'b0;
    dout_d  = dout_q;
    lout_d  = 1'b0;
    seq_d   = seq_q;
    done_d  = 1'b0;
    ecode_d = ecode_q;
    good_d  = good_q;
    bad_d   = bad_q;
    term    = 1'b0;
    e       = err_q;
    if (bus.validIn) begin
      unique case (state_q)
        IDLE: begin
          e     = 4'd0;
          seq_d = hdr_seq;
          exp_d = hdr_seq + 16'd1;
          len_d = hdr_len;
          cnt_d = 7'd0;
          if (hdr_seq != exp_q) e[1] = 1'b1;
          if (hdr_bad) begin
            e[0] = 1'b1;
            if (bus.lastIn) term = 1'b1;
            else state_d = DROP;
          end else if (bus.lastIn) begin
            e[2] = 1'b1;
            term = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          vout_d = 1'b1;
          dout_d = bus.dataIn;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            lout_d = 1'b1;
            if (bus.lastIn) begin
              e[2]    = 1'b1;
              term    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = FOOTER;
            end
          end else if (bus.lastIn) begin
            lout_d  = 1'b1;
            e[2]    = 1'b1;
            term    = 1'b1;
            state_d = IDLE;
          end
        end
        FOOTER: begin
          if (bus.dataIn != FOOTER_WORD) e[3] = 1'b1;
          if (bus.lastIn) begin
            term    = 1'b1;
            state_d = IDLE;
          end else begin
            e[3]    = 1'b1;
            state_d = DROP;
          end
        end
        DROP: begin
          if (bus.lastIn) begin
            term    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      err_d = e;
      if (term) begin
        done_d  = 1'b1;
        ecode_d = e;
        if (e == 4'd0) good_d = good_q + 16'd1;
        else bad_d = bad_q + 16'd1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      len_q   <= 7'd0;
      cnt_q   <= 7'd0;
      exp_q   <= 16'h0001;
      err_q   <= 4'd0;
      vout_q  <= 1'b0;
      dout_q  <= 32'd0;
      lout_q  <= 1'b0;
      seq_q   <= 16'd0;
      done_q  <= 1'b0;
      ecode_q <= 4'd0;
      good_q  <= 16'd0;
      bad_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      lout_q  <= lout_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      ecode_q <= ecode_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.validOut  = vout_q;
  assign bus.dataOut   = dout_q;
  assign bus.lastOut   = lout_q;
  assign bus.seqOut    = seq_q;
  assign bus.pktDone   = done_q;
  assign bus.errCode   = ecode_q;
  assign bus.goodCount = good_q;
  assign bus.errCount  = bad_q;

endmodule

// File: tb/tb_flexi_packet_parser.sv
// Directed bench for flexi_packet_parser: each step drives
// one cycle and checks the registered response right after.
module tb_flexi_packet_parser;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  flexi_packet_parser_if bus ();

  flexi_packet_parser #(
    .MAX_PAYLOAD(100),
    .FOOTER_WORD(32'hFFFFFFFF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [31:0] d,
                      input logic l);
    @(negedge clk);
    bus.validIn = v;
    bus.dataIn  = d;
    bus.lastIn  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic v,
                     input logic [31:0] d, input logic l);
    chk({tag, "_valid"}, {31'd0, bus.validOut}, {31'd0, v});
    if (v) begin
      chk({tag, "_data"}, bus.dataOut, d);
      chk({tag, "_last"}, {31'd0, bus.lastOut}, {31'd0, l});
    end
  endtask

  task automatic done(input string tag, input logic p,
                      input logic [3:0] e);
    chk({tag, "_done"}, {31'd0, bus.pktDone}, {31'd0, p});
    if (p) chk({tag, "_err"}, {28'd0, bus.errCode}, {28'd0, e});
  endtask

  task automatic cnts(input string tag, input int g,
                      input int b);
    chk({tag, "_good"}, {16'd0, bus.goodCount}, 32'(g));
    chk({tag, "_bad"}, {16'd0, bus.errCount}, 32'(b));
  endtask

  initial begin
    bus.validIn = 1'b0;
    bus.dataIn  = 32'd0;
    bus.lastIn  = 1'b0;

    resetn = 1'b0;
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    out("rst", 1'b0, 32'd0, 1'b0);
    chk("rst_data", bus.dataOut, 32'd0);
    chk("rst_lastout", {31'd0, bus.lastOut}, 32'd0);
    chk("rst_seq", {16'd0, bus.seqOut}, 32'd0);
    chk("rst_errcode", {28'd0, bus.errCode}, 32'd0);
    done("rst", 1'b0, 4'd0);
    cnts("rst", 0, 0);
    resetn = 1'b1;

    // clean frame, seq 1, L=3
    step(1'b1, 32'h0001_0003, 1'b0);
    out("f1_hdr", 1'b0, 32'd0, 1'b0);
    chk("f1_seq", {16'd0, bus.seqOut}, 32'h1);
    step(1'b1, 32'hAAAA_0001, 1'b0);
    out("f1_a", 1'b1, 32'hAAAA_0001, 1'b0);
    step(1'b1, 32'hBBBB_0002, 1'b0);
    out("f1_b", 1'b1, 32'hBBBB_0002, 1'b0);
    done("f1_b", 1'b0, 4'd0);
    step(1'b1, 32'hCCCC_0003, 1'b0);
    out("f1_c", 1'b1, 32'hCCCC_0003, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    out("f1_ftr", 1'b0, 32'd0, 1'b0);
    done("f1_ftr", 1'b1, 4'b0000);
    cnts("f1", 1, 0);
    step(1'b0, 32'd0, 1'b0);
    done("f1_after", 1'b0, 4'd0);

    // seq jumps to 3 while 2 expected
    step(1'b1, 32'h0003_0002, 1'b0);
    step(1'b1, 32'h1111_1111, 1'b0);
    out("f2_a", 1'b1, 32'h1111_1111, 1'b0);
    step(1'b1, 32'h2222_2222, 1'b0);
    out("f2_b", 1'b1, 32'h2222_2222, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    done("f2", 1'b1, 4'b0010);
    cnts("f2", 1, 1);

    // seq 4 expected now; truncated at word 2 of 3
    step(1'b1, 32'h0004_0003, 1'b0);
    step(1'b1, 32'h3333_0001, 1'b0);
    out("f3_a", 1'b1, 32'h3333_0001, 1'b0);
    step(1'b1, 32'h3333_0002, 1'b1);
    out("f3_b", 1'b1, 32'h3333_0002, 1'b1);
    done("f3", 1'b1, 4'b0100);
    cnts("f3", 1, 2);

    // next word is a header again, seq 5 clean
    step(1'b1, 32'h0005_0001, 1'b0);
    out("f4_hdr", 1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h4444_4444, 1'b0);
    out("f4_a", 1'b1, 32'h4444_4444, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    done("f4", 1'b1, 4'b0000);
    cnts("f4", 2, 2);

    // reserved bit set: dropped, no payload output
    step(1'b1, 32'h0006_0080, 1'b0);
    out("f5_hdr", 1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h5555_0001, 1'b0);
    out("f5_w1", 1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h5555_0002, 1'b0);
    out("f5_w2", 1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h5555_0003, 1'b0);
    done("f5_w3", 1'b0, 4'd0);
    step(1'b1, 32'h5555_0004, 1'b1);
    out("f5_w4", 1'b0, 32'd0, 1'b0);
    done("f5", 1'b1, 4'b0001);
    cnts("f5", 2, 3);

    // bad footer value
    step(1'b1, 32'h0007_0002, 1'b0);
    step(1'b1, 32'h6666_0001, 1'b0);
    out("f6_a", 1'b1, 32'h6666_0001, 1'b0);
    step(1'b1, 32'h6666_0002, 1'b0);
    out("f6_b", 1'b1, 32'h6666_0002, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b1);
    out("f6_ftr", 1'b0, 32'd0, 1'b0);
    done("f6", 1'b1, 4'b1000);
    cnts("f6", 2, 4);

    // same again with idle cycles between beats
    step(1'b1, 32'h0008_0002, 1'b0);
    step(1'b0, 32'hDEAD_BEEF, 1'b1);
    out("f7_gap0", 1'b0, 32'd0, 1'b0);
    done("f7_gap0", 1'b0, 4'd0);
    step(1'b1, 32'h6666_0001, 1'b0);
    out("f7_a", 1'b1, 32'h6666_0001, 1'b0);
    step(1'b0, 32'hDEAD_BEEF, 1'b1);
    out("f7_gap1", 1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h6666_0002, 1'b0);
    out("f7_b", 1'b1, 32'h6666_0002, 1'b1);
    step(1'b0, 32'hFFFF_FFFF, 1'b1);
    out("f7_gap2", 1'b0, 32'd0, 1'b0);
    done("f7_gap2", 1'b0, 4'd0);
    step(1'b1, 32'h1234_5678, 1'b1);
    done("f7", 1'b1, 4'b1000);
    cnts("f7", 2, 5);

    // footer without lastIn: drop until lastIn
    step(1'b1, 32'h0009_0001, 1'b0);
    step(1'b1, 32'h7777_7777, 1'b0);
    out("f8_a", 1'b1, 32'h7777_7777, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    done("f8_ftr", 1'b0, 4'd0);
    step(1'b1, 32'h8888_8888, 1'b1);
    out("f8_end", 1'b0, 32'd0, 1'b0);
    done("f8", 1'b1, 4'b1000);
    cnts("f8", 2, 6);

    // L=0 header with lastIn terminates at once
    step(1'b1, 32'h000A_0000, 1'b1);
    done("f9", 1'b1, 4'b0001);
    // L=101 exceeds limit
    step(1'b1, 32'h000B_0065, 1'b1);
    done("f10", 1'b1, 4'b0001);
    // L=100 is legal; lone header is truncation
    step(1'b1, 32'h000C_0064, 1'b1);
    done("f11", 1'b1, 4'b0100);
    cnts("f11", 2, 9);
    // expected seq wraps FFFF -> 0000
    step(1'b1, 32'hFFFF_0064, 1'b1);
    done("f12", 1'b1, 4'b0110);
    step(1'b1, 32'h0000_0064, 1'b1);
    done("f13", 1'b1, 4'b0100);

    // reset in mid-payload
    step(1'b1, 32'h000D_0003, 1'b0);
    step(1'b1, 32'h9999_0001, 1'b0);
    out("f14_a", 1'b1, 32'h9999_0001, 1'b0);
    resetn = 1'b0;
    step(1'b1, 32'h9999_0002, 1'b0);
    resetn = 1'b1;
    out("f14_rst", 1'b0, 32'd0, 1'b0);
    chk("f14_rst_seq", {16'd0, bus.seqOut}, 32'd0);
    done("f14_rst", 1'b0, 4'd0);
    cnts("f14_rst", 0, 0);
    step(1'b0, 32'd0, 1'b0);
    done("f14_idle", 1'b0, 4'd0);

    // fresh seq-1 frame after reset
    step(1'b1, 32'h0001_0001, 1'b0);
    out("f15_hdr", 1'b0, 32'd0, 1'b0);
    step(1'b1, 32'hABCD_EF01, 1'b0);
    out("f15_a", 1'b1, 32'hABCD_EF01, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    done("f15", 1'b1, 4'b0000);
    cnts("f15", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flexi_packet_parser.md
FLEXI_PACKET_PARSER -- requirements
Module: flexi_packet_parser

Interface
REQ-001 Parameter MAX_PAYLOAD, default 100, SHALL set the largest legal payload length in words.
REQ-002 Parameter FOOTER_WORD, default 32'hFFFFFFFF, SHALL set the required footer value.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  SHALL be a synchronous, active-low reset.
REQ-005 validIn  input  1  SHALL qualify dataIn/lastIn; no backpressure exists.
REQ-006 dataIn  input  32  SHALL carry the framed word: header, payload, footer.
REQ-007 lastIn  input  1  SHALL mark the final word of a frame.
REQ-008 validOut  output  1  SHALL qualify the extracted payload word.
REQ-009 dataOut  output  32  SHALL carry the extracted payload word.
REQ-010 lastOut  output  1  SHALL mark the final payload word of a packet.
REQ-011 seqOut  output  16  SHALL hold the sequence number of the current or most recent header.
REQ-012 pktDone  output  1  SHALL pulse for one cycle at frame termination.
REQ-013 errCode  output  4  SHALL give frame error flags, valid while pktDone=1: [0] header, [1] sequence, [2] length/truncation, [3] footer.
REQ-014 goodCount, errCount  output  16 each  SHALL count clean and errored frames.

Function
REQ-015 Header format SHALL be: [31:16] sequence, [15:7] reserved (must be zero), [6:0] payload length L.
REQ-016 States SHALL be IDLE, PAYLOAD, FOOTER, DROP; state advances only on validIn=1 beats, and a cycle with validIn=0 holds all state.
REQ-017 IDLE: the first valid word SHALL be the header, and it SHALL be latched into seqOut and the length counter.
REQ-018 A header with reserved bits nonzero, L=0, or L>MAX_PAYLOAD SHALL set errCode[0] and go to DROP, or to IDLE with frame termination if lastIn=1.
REQ-019 A valid header with lastIn=1 SHALL set errCode[2], terminate the frame, and return to IDLE.
REQ-020 A valid header with lastIn=0 SHALL go to PAYLOAD.
REQ-021 The expected sequence number SHALL reset to 16'h0001; a header sequence mismatch SHALL set errCode[1] without dropping payload, and the expected value SHALL become header sequence + 1, wrapping 16'hFFFF -> 16'h0000.
REQ-022 PAYLOAD: each valid word SHALL appear on dataOut with validOut=1 exactly one cycle later; validOut SHALL be 0 in all other cycles.
REQ-023 lastOut SHALL be 1 on payload word L; the state SHALL then go to FOOTER.
REQ-024 lastIn=1 before payload word L SHALL set errCode[2], output that word with lastOut=1, terminate the frame, and go to IDLE.
REQ-025 FOOTER: the word SHALL equal FOOTER_WORD with lastIn=1; on success the frame terminates and the state goes to IDLE.
REQ-026 A footer value mismatch SHALL set errCode[3].
REQ-027 A footer beat with lastIn=0 SHALL set errCode[3] and go to DROP, with no termination yet.
REQ-028 DROP SHALL discard words with validOut=0 until a lastIn=1 beat, then terminate the frame and go to IDLE.
REQ-029 Footer words SHALL never be forwarded; header words SHALL never be forwarded.
REQ-030 Frame termination: pktDone=1 and errCode SHALL be registered one cycle after the terminating beat, aligned with the lastOut beat when one exists.
REQ-031 At termination, goodCount SHALL increment if errCode=0, else errCount SHALL increment; both wrap at 16 bits.
REQ-032 Error flags SHALL accumulate per frame and SHALL clear when the next header is accepted.

Reset
REQ-033 With resetn=0 at a clock edge, the block SHALL go to IDLE and clear validOut, lastOut, pktDone, dataOut, errCode, goodCount, errCount, and seqOut to 0, with the expected sequence set to 16'h0001.
REQ-034 Reset in mid-frame SHALL abandon the frame with no pktDone; the following words SHALL be parsed as a new header.

Verification
REQ-035 Header 32'h0001_0003, payloads A,B,C, footer FFFFFFFF with lastIn -> A,B,C out at 1-cycle latency, lastOut on C, pktDone with errCode=0, goodCount=1.
REQ-036 Two frames with seq 1 then 3 -> second frame payload forwarded, errCode=4'b0010, errCount=1, expected sequence becomes 4.
REQ-037 Header length 3, lastIn on payload word 2 -> lastOut on word 2, errCode=4'b0100, next word treated as a header.
REQ-038 Header 32'h0001_0080 (reserved bit set), 4 following words, last with lastIn -> no validOut, errCode=4'b0001 one cycle after the lastIn beat.
REQ-039 Footer 32'h12345678 with lastIn -> payload intact, errCode=4'b1000; repeat with validIn gaps between every beat -> identical output words.
REQ-040 resetn=0 for one cycle mid-payload -> outputs and counters zero, no pktDone; a subsequent clean seq-1 frame is accepted with errCode=0.
